// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver: assembles E0/F0-prefixed scan codes
// and reports the completed code, the break flag and framing errors.
module ps2_scancode_rx #(
  parameter int unsigned TIMEOUT = 5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] scancode,
  output logic        is_release,   // 1 = last completed code was a break (F0) event
  output logic        valid,
  output logic        frame_err
);

  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [BYTE_W-1:0] EXT_BYTE = 8'hE0;
  localparam logic [BYTE_W-1:0] BRK_BYTE = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               clk_s1_q, clk_s2_q, clk_prev_q;
  logic               dat_s1_q, dat_s2_q;
  logic [BYTE_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               par_q, par_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               ext_q, ext_d;
  logic               brk_q, brk_d;
  logic [15:0]        scancode_q, scancode_d;
  logic               release_q, release_d;
  logic               valid_q, valid_d;
  logic               frame_err_q, frame_err_d;

  logic fall_c;
  logic good_c;

  // Synchronizers idle high, matching an idle PS/2 bus
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall_c = clk_prev_q & ~clk_s2_q;
  // Odd parity over data + parity bit, and a high stop bit
  assign good_c = (^{shift_q, par_q}) & dat_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      scancode_q  <= 16'h0000;
      release_q   <= 1'b0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      scancode_q  <= scancode_d;
      release_q   <= release_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    par_d       = par_q;
    tmo_d       = tmo_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    scancode_d  = scancode_q;
    release_d   = release_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (fall_c && !dat_s2_q) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      S_DATA: begin
        if (fall_c) begin
          shift_d   = {dat_s2_q, shift_q[BYTE_W-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
            state_d = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (fall_c) begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall_c) begin
          state_d = S_IDLE;
          if (!good_c) begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end else if (shift_q == EXT_BYTE) begin
            ext_d = 1'b1;
          end else if (shift_q == BRK_BYTE) begin
            brk_d = 1'b1;
          end else begin
            scancode_d = {(ext_q ? EXT_BYTE : 8'h00), shift_q};
            release_d  = brk_q;
            valid_d    = 1'b1;
            ext_d      = 1'b0;
            brk_d      = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abandon a stalled frame silently, dropping any pending prefix
    if (state_q != S_IDLE) begin
      if (fall_c) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        state_d   = S_IDLE;
        tmo_d     = '0;
        shift_d   = '0;
        bit_cnt_d = '0;
        ext_d     = 1'b0;
        brk_d     = 1'b0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  assign scancode   = scancode_q;
  assign is_release = release_q;
  assign valid      = valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: bit-bangs PS/2 frames and checks the
// decoded code, break flag, pulses and latency against hand-computed values.
module tb_ps2_scancode_rx;

  localparam int unsigned TB_TMO = 300;
  localparam int unsigned HALF   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] scancode;
  logic        rel;
  logic        valid;
  logic        frame_err;

  int n_vec = 0;
  int n_bad = 0;

  int cyc = 0;
  int n_valid = 0, n_err = 0, n_overlap = 0, n_wide = 0;
  int last_valid_cyc = 0, stop_cyc = 0;
  int v0 = 0, e0 = 0;
  logic valid_prev = 1'b0;
  logic err_prev = 1'b0;

  ps2_scancode_rx #(.TIMEOUT(TB_TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scancode   (scancode),
    .is_release (rel),
    .valid      (valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor sampled on the falling clk edge
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (frame_err) n_err++;
    if (valid && frame_err) n_overlap++;
    if ((valid && valid_prev) || (frame_err && err_prev)) n_wide++;
    valid_prev = valid;
    err_prev   = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    v0 = n_valid;
    e0 = n_err;
  endtask

  // Sends the first nbits of a frame (start, 8 data LSB first, parity, stop)
  task automatic send(input logic [7:0] b, input logic par_flip, input logic stop_bit,
                      input int nbits);
    logic [10:0] f;
    f = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] b);
    send(b, 1'b0, 1'b1, 11);
  endtask

  task automatic expect_out(input string tag, input int dv, input int de,
                            input logic [15:0] sc, input logic r);
    check({tag, ".valid_cnt"}, 32'(n_valid - v0), 32'(dv));
    check({tag, ".err_cnt"},   32'(n_err - e0),   32'(de));
    check({tag, ".scancode"},  32'(scancode),     32'(sc));
    check({tag, ".release"},   32'(rel),          32'(r));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst.scancode",  32'(scancode),  32'h0);
    check("rst.release",   32'(rel),       32'h0);
    check("rst.valid",     32'(valid),     32'h0);
    check("rst.frame_err", 32'(frame_err), 32'h0);
    repeat (5) @(negedge clk);

    // Extended make code
    mark(); frame(8'hE0);
    expect_out("e0_only", 0, 0, 16'h0000, 1'b0);
    frame(8'h6B);
    expect_out("e06b", 1, 0, 16'hE06B, 1'b0);
    check("latency", 32'(last_valid_cyc - stop_cyc), 32'd3);

    // Plain make, then extended break
    mark(); frame(8'h1C);
    expect_out("1c", 1, 0, 16'h001C, 1'b0);
    mark(); frame(8'hE0); frame(8'hF0); frame(8'h72);
    expect_out("e0f072", 1, 0, 16'hE072, 1'b1);
    mark(); frame(8'h1C);
    expect_out("flags_clear", 1, 0, 16'h001C, 1'b0);

    // Parity error keeps the previous code
    mark(); send(8'h75, 1'b1, 1'b1, 11);
    expect_out("bad_par", 0, 1, 16'h001C, 1'b0);
    mark(); frame(8'h74);
    expect_out("74", 1, 0, 16'h0074, 1'b0);

    // Stop-bit error drops the pending E0
    mark(); frame(8'hE0); send(8'h6B, 1'b0, 1'b0, 11);
    expect_out("bad_stop", 0, 1, 16'h0074, 1'b0);
    mark(); frame(8'h6B);
    expect_out("6b_after_err", 1, 0, 16'h006B, 1'b0);

    // Repeated prefixes
    mark(); frame(8'hE0); frame(8'hE0); frame(8'hF0); frame(8'hF0); frame(8'h75);
    expect_out("rep_prefix", 1, 0, 16'hE075, 1'b1);

    // Timeout on a partial frame, with a pending E0 that must be dropped
    mark(); frame(8'hE0); send(8'h6B, 1'b0, 1'b1, 5);
    repeat (TB_TMO + 10) @(negedge clk);
    expect_out("timeout", 0, 0, 16'hE075, 1'b1);
    frame(8'h6B);
    expect_out("after_tmo", 1, 0, 16'h006B, 1'b0);

    // Reset mid-frame with a pending F0
    frame(8'hF0); send(8'h72, 1'b0, 1'b1, 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst.scancode",  32'(scancode),  32'h0);
    check("mid_rst.release",   32'(rel),       32'h0);
    check("mid_rst.valid",     32'(valid),     32'h0);
    check("mid_rst.frame_err", 32'(frame_err), 32'h0);
    repeat (5) @(negedge clk);
    mark(); frame(8'h72);
    expect_out("after_rst", 1, 0, 16'h0072, 1'b0);

    check("pulse_overlap", 32'(n_overlap), 32'd0);
    check("pulse_width",   32'(n_wide),    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
